lsu_exec: RTL and testbench

Load/store execution unit. Consumes the LOAD/STORE operations produced by the decoder (op, base register value, store-data register value, sign-extended offset) and performs the memory access on a single-port data-memory request/grant/rvalid interface. Sits between the issue stage and the data cache/memory, and returns a load result or store completion to writeback. One operation in flight at a time.

---
 rtl/lsu_exec.sv | 239 +++++++++++++++++++++++
 tb/tb_lsu_exec.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_exec.sv
// lsu_exec -- load/store execution unit, one operation in flight.
//
// Takes a LOAD/STORE from issue, forms ea = base + offset, checks
// alignment and legality, performs one access on a single-port
// req/gnt/rvalid memory interface, and returns a load result or store
// completion (or an exception) to writeback.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   op_valid_i / op_ready_o       issue handshake
//   op_i, base_i, offset_i,
//   sdata_i, trans_id_i           operation, rs1, imm, rs2, scoreboard id
//   mem_req_o / mem_gnt_i         memory request handshake
//   mem_addr_o, mem_we_o,
//   mem_be_o, mem_wdata_o         doubleword address, write flag, lanes, data
//   mem_rvalid_i, mem_rdata_i     load return
//   res_valid_o / res_ready_i     writeback handshake
//   res_trans_id_o, res_data_o,
//   res_ex_o, res_ex_cause_o      result id, data, exception flag and cause
//
// Build option: define LSU_ADDR_REG_EN to insert an AGEN state that
// registers the effective address before the alignment check and lane
// generation (adds one cycle to every path).

module lsu_exec #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned TRANS_ID_W = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  op_valid_i,
    output logic                  op_ready_o,
    input  logic [3:0]            op_i,
    input  logic [XLEN-1:0]       base_i,
    input  logic [XLEN-1:0]       offset_i,
    input  logic [XLEN-1:0]       sdata_i,
    input  logic [TRANS_ID_W-1:0] trans_id_i,
    output logic                  mem_req_o,
    input  logic                  mem_gnt_i,
    output logic [XLEN-1:0]       mem_addr_o,
    output logic                  mem_we_o,
    output logic [7:0]            mem_be_o,
    output logic [XLEN-1:0]       mem_wdata_o,
    input  logic                  mem_rvalid_i,
    input  logic [XLEN-1:0]       mem_rdata_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [TRANS_ID_W-1:0] res_trans_id_o,
    output logic [XLEN-1:0]       res_data_o,
    output logic                  res_ex_o,
    output logic [1:0]            res_ex_cause_o
);

    typedef enum logic [2:0] {IDLE, AGEN, REQ, WAIT, RESP} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              op_q;
    logic [TRANS_ID_W-1:0]   tid_q;
    logic [XLEN-1:0]         addr_q;
    logic [7:0]              be_q;
    logic [XLEN-1:0]         wdata_q;
    logic [2:0]              b_q;
    logic                    ex_q;
    logic [1:0]              cause_q;
    logic [XLEN-1:0]         data_q;

    // Address-generation sources: live inputs, or registered copies when
    // the AGEN stage is built in.
    logic [3:0]              ag_op;
    logic [XLEN-1:0]         ag_ea;
    logic [XLEN-1:0]         ag_sdata;
    logic                    cap_agen;

`ifdef LSU_ADDR_REG_EN
    logic [XLEN-1:0]         ea_q;
    logic [XLEN-1:0]         sdata_q;

    assign ag_op    = op_q;
    assign ag_ea    = ea_q;
    assign ag_sdata = sdata_q;
    assign cap_agen = (state_q == AGEN);
`else
    assign ag_op    = op_i;
    assign ag_ea    = base_i + offset_i;
    assign ag_sdata = sdata_i;
    assign cap_agen = (state_q == IDLE) && op_valid_i;
`endif

    logic [2:0]              ag_b;
    logic [XLEN-1:0]         ag_addr;
    logic [7:0]              ag_be;
    logic [XLEN-1:0]         ag_wdata;
    logic                    ag_illegal;
    logic                    ag_misal;
    logic                    ag_ex;
    logic [1:0]              ag_cause;

    always_comb begin
        ag_b       = ag_ea[2:0];
        ag_addr    = {ag_ea[XLEN-1:3], 3'b000};
        // Legal codes: loads 0..6, stores 8..11.
        ag_illegal = ag_op[3] ? ag_op[2] : (ag_op == 4'd7);
        ag_be      = '0;
        ag_misal   = 1'b0;
        case (ag_op[1:0])
            2'd0:    ag_be = 8'h01;
            2'd1:    begin ag_be = 8'h03; ag_misal = ag_b[0];     end
            2'd2:    begin ag_be = 8'h0F; ag_misal = |ag_b[1:0];  end
            default: begin ag_be = 8'hFF; ag_misal = |ag_b;       end
        endcase
        ag_be    = ag_be << ag_b;
        ag_wdata = ag_sdata << {ag_b, 3'b000};
        ag_ex    = ag_illegal | ag_misal;
        if (ag_illegal)
            ag_cause = 2'd3;
        else if (ag_misal)
            ag_cause = ag_op[3] ? 2'd2 : 2'd1;
        else
            ag_cause = 2'd0;
    end

    // Load extraction: move lane b down to bit 0, then sign/zero extend.
    logic [XLEN-1:0] ld_shift;
    logic [XLEN-1:0] ld_data;
    logic            ld_sign;

    always_comb begin
        ld_shift = mem_rdata_i >> {b_q, 3'b000};
        ld_sign  = 1'b0;
        ld_data  = ld_shift;
        case (op_q[1:0])
            2'd0: begin
                ld_sign = ~op_q[2] & ld_shift[7];
                ld_data = {{(XLEN-8){ld_sign}}, ld_shift[7:0]};
            end
            2'd1: begin
                ld_sign = ~op_q[2] & ld_shift[15];
                ld_data = {{(XLEN-16){ld_sign}}, ld_shift[15:0]};
            end
            2'd2: begin
                ld_sign = ~op_q[2] & ld_shift[31];
                ld_data = {{(XLEN-32){ld_sign}}, ld_shift[31:0]};
            end
            default: ld_data = ld_shift;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        op_ready_o  = 1'b0;
        mem_req_o   = 1'b0;
        res_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                op_ready_o = 1'b1;
                if (op_valid_i) begin
`ifdef LSU_ADDR_REG_EN
                    state_d = AGEN;
`else
                    state_d = ag_ex ? RESP : REQ;
`endif
                end
            end
            AGEN: state_d = ag_ex ? RESP : REQ;
            REQ: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i)
                    state_d = op_q[3] ? RESP : WAIT;
            end
            WAIT: begin
                if (mem_rvalid_i)
                    state_d = RESP;
            end
            RESP: begin
                res_valid_o = 1'b1;
                if (res_ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q    <= '0;
            tid_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            b_q     <= '0;
            ex_q    <= 1'b0;
            cause_q <= '0;
            data_q  <= '0;
`ifdef LSU_ADDR_REG_EN
            ea_q    <= '0;
            sdata_q <= '0;
`endif
        end else begin
            if (state_q == IDLE && op_valid_i) begin
                op_q   <= op_i;
                tid_q  <= trans_id_i;
                // Stores and exceptions report zero data.
                data_q <= '0;
`ifdef LSU_ADDR_REG_EN
                ea_q    <= base_i + offset_i;
                sdata_q <= sdata_i;
`endif
            end
            if (cap_agen) begin
                addr_q  <= ag_addr;
                be_q    <= ag_be;
                wdata_q <= ag_wdata;
                b_q     <= ag_b;
                ex_q    <= ag_ex;
                cause_q <= ag_cause;
            end
            if (state_q == WAIT && mem_rvalid_i)
                data_q <= ld_data;
        end
    end

    // Outputs are forced to zero outside the state that owns them.
    assign mem_addr_o     = (state_q == REQ)  ? addr_q  : '0;
    assign mem_be_o       = (state_q == REQ)  ? be_q    : '0;
    assign mem_wdata_o    = (state_q == REQ)  ? wdata_q : '0;
    assign mem_we_o       = (state_q == REQ)  && op_q[3];
    assign res_data_o     = (state_q == RESP) ? data_q  : '0;
    assign res_trans_id_o = (state_q == RESP) ? tid_q   : '0;
    assign res_ex_cause_o = (state_q == RESP) ? cause_q : '0;
    assign res_ex_o       = (state_q == RESP) && ex_q;

endmodule

// File: tb/tb_lsu_exec.sv
module tb_lsu_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op;
    logic [63:0] base, offset, sdata;
    logic [2:0]  trans_id;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_be;
    logic        res_valid, res_ready, res_ex;
    logic [2:0]  res_trans_id;
    logic [63:0] res_data;
    logic [1:0]  res_ex_cause;

    always #5 clk = ~clk;

    lsu_exec #(.XLEN(64), .TRANS_ID_W(3)) dut (
        .clk_i(clk), .rst_i(rst),
        .op_valid_i(op_valid), .op_ready_o(op_ready), .op_i(op),
        .base_i(base), .offset_i(offset), .sdata_i(sdata), .trans_id_i(trans_id),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr),
        .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_trans_id_o(res_trans_id), .res_data_o(res_data),
        .res_ex_o(res_ex), .res_ex_cause_o(res_ex_cause)
    );

`ifdef LSU_ADDR_REG_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    int checks = 0;
    int errors = 0;

    // Observations from the last driven operation.
    logic [63:0] o_addr, o_wdata, o_data;
    logic [7:0]  o_be;
    logic        o_we, o_ex;
    logic [1:0]  o_cause;
    logic [2:0]  o_tid;
    int          o_nreq, o_lat;
    bit          o_stable, o_hold_ok, o_ready_back, o_timeout;

    // Reference: effective address and access semantics from plain arithmetic.
    function automatic void model(input logic [3:0] mop, input logic [63:0] mbase, moff, msd, mrd,
                                  output logic [63:0] addr, output logic [7:0] be,
                                  output logic [63:0] wdata, output logic [63:0] data,
                                  output logic ex, output logic [1:0] cause, output bit st);
        logic [63:0] ea, v, mask;
        int sz, b;
        bit legal;
        ea    = mbase + moff;
        b     = int'(ea % 64'd8);
        st    = (mop >= 4'd8);
        legal = (mop <= 4'd6) || (mop >= 4'd8 && mop <= 4'd11);
        sz    = 1 << (mop % 4);
        addr  = ea - 64'(b);
        be = '0; wdata = '0; data = '0; ex = 1'b0; cause = 2'd0;
        if (!legal) begin
            ex = 1'b1; cause = 2'd3;
        end else if (ea % 64'(sz) != 0) begin
            ex = 1'b1; cause = st ? 2'd2 : 2'd1;
        end else begin
            be = 8'(((1 << sz) - 1) << b);
            if (st) begin
                wdata = msd << (8 * b);
            end else begin
                v = mrd >> (8 * b);
                if (sz < 8) begin
                    mask = (64'd1 << (8 * sz)) - 64'd1;
                    v = v & mask;
                    if (mop < 4'd4 && v >= (64'd1 << (8 * sz - 1)))
                        v = v - (64'd1 << (8 * sz));
                end
                data = v;
            end
        end
    endfunction

    // Drives one operation through issue, memory and writeback.
    // gd: REQ cycles before grant; rd: WAIT cycles before rvalid;
    // rr: RESP cycles before res_ready; noise: stray rvalid outside WAIT.
    task automatic do_op(input logic [3:0] iop, input logic [63:0] ibase, ioff, isd, irdata,
                         input logic [2:0] itid, input int gd, input int rd, input int rr,
                         input bit noise);
        int cyc, nreq, nw, nres;
        bit granted, done;
        o_stable = 1; o_hold_ok = 1; o_timeout = 0; o_lat = -1; o_ready_back = 0;
        o_nreq = 0;
        @(negedge clk);
        op_valid = 1'b1; op = iop; base = ibase; offset = ioff; sdata = isd; trans_id = itid;
        cyc = 0;
        while (!op_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!op_ready) o_timeout = 1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op = 4'($urandom); base = {$urandom, $urandom}; offset = {$urandom, $urandom};
        sdata = {$urandom, $urandom}; trans_id = 3'($urandom);
        cyc = 0; nreq = 0; nw = 0; nres = 0; granted = 0; done = o_timeout;
        while (!done) begin
            @(negedge clk);
            cyc++;
            mem_gnt = 1'b0; mem_rvalid = 1'b0; res_ready = 1'b0;
            mem_rdata = {$urandom, $urandom};
            if (op_ready) o_hold_ok = 0;
            if (cyc > 200) begin
                o_timeout = 1;
                done = 1;
            end else if (res_valid) begin
                if (nres == 0) begin
                    o_lat = cyc; o_data = res_data; o_ex = res_ex;
                    o_cause = res_ex_cause; o_tid = res_trans_id;
                end else if (res_data !== o_data || res_ex !== o_ex ||
                             res_ex_cause !== o_cause || res_trans_id !== o_tid) begin
                    o_hold_ok = 0;
                end
                if (noise) mem_rvalid = 1'($urandom);
                if (nres >= rr) res_ready = 1'b1;
                nres++;
                if (res_ready) begin
                    @(negedge clk);
                    o_ready_back = op_ready && !res_valid;
                    res_ready = 1'b0; mem_rvalid = 1'b0;
                    done = 1;
                end
            end else if (mem_req) begin
                if (nreq == 0) begin
                    o_addr = mem_addr; o_be = mem_be; o_we = mem_we; o_wdata = mem_wdata;
                end else if (mem_addr !== o_addr || mem_be !== o_be ||
                             mem_we !== o_we || mem_wdata !== o_wdata) begin
                    o_stable = 0;
                end
                nreq++;
                mem_gnt = (nreq > gd);
                if (noise) mem_rvalid = 1'($urandom);
                if (mem_gnt) granted = 1;
            end else if (granted) begin
                mem_rvalid = (nw >= rd);
                if (mem_rvalid) mem_rdata = irdata;
                nw++;
            end
        end
        o_nreq = nreq;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({op_ready, mem_req, mem_we, res_valid, res_ex} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 10000", {op_ready, mem_req, mem_we, res_valid, res_ex});
        end
        checks++;
        if (mem_be !== 8'h00 || mem_addr !== 64'd0 || mem_wdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_mem: be %h addr %h wdata %h expected all zero", mem_be, mem_addr, mem_wdata);
        end
        checks++;
        if (res_data !== 64'd0 || res_ex_cause !== 2'd0 || res_trans_id !== 3'd0) begin
            errors++;
            $display("FAIL reset_res: data %h cause %0d id %0d expected zero", res_data, res_ex_cause, res_trans_id);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [63:0] base, off, sd, rdata, addr;
        logic [7:0]  be;
        logic [63:0] wdata, data;
        logic        ex;
        logic [1:0]  cause;
    } dcase_t;

    task automatic test_directed;
        dcase_t tc [11];
        int exp_lat;
        tc[0]  = '{4'd0,  64'h1000, 64'h3, 64'h0, 64'h0000_0000_80FF_0000, 64'h1000, 8'h08, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 2'd0};
        tc[1]  = '{4'd4,  64'h1000, 64'h3, 64'h0, 64'h0000_0000_80FF_0000, 64'h1000, 8'h08, 64'h0, 64'h80, 1'b0, 2'd0};
        tc[2]  = '{4'd9,  64'h2000, 64'hFFFF_FFFF_FFFF_FFFE, 64'hABCD, 64'h0, 64'h1FF8, 8'hC0, 64'hABCD_0000_0000_0000, 64'h0, 1'b0, 2'd0};
        tc[3]  = '{4'd2,  64'h1000, 64'h2, 64'h0, 64'h0, 64'h0, 8'h00, 64'h0, 64'h0, 1'b1, 2'd1};
        tc[4]  = '{4'd11, 64'h1000, 64'h4, 64'h5, 64'h0, 64'h0, 8'h00, 64'h0, 64'h0, 1'b1, 2'd2};
        tc[5]  = '{4'd7,  64'h1000, 64'h0, 64'h0, 64'h0, 64'h0, 8'h00, 64'h0, 64'h0, 1'b1, 2'd3};
        tc[6]  = '{4'd6,  64'hFFFF_FFFF_FFFF_FFF8, 64'h10, 64'h0, 64'h1234_5678_DEAD_BEEF, 64'h8, 8'h0F, 64'h0, 64'h0000_0000_DEAD_BEEF, 1'b0, 2'd0};
        tc[7]  = '{4'd15, 64'h3001, 64'h0, 64'h0, 64'h0, 64'h0, 8'h00, 64'h0, 64'h0, 1'b1, 2'd3};
        tc[8]  = '{4'd1,  64'h3000, 64'h6, 64'h0, 64'h8001_0000_0000_0000, 64'h3000, 8'hC0, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 2'd0};
        tc[9]  = '{4'd10, 64'h4000, 64'h4, 64'h1122_3344_5566_7788, 64'h0, 64'h4000, 8'hF0, 64'h5566_7788_0000_0000, 64'h0, 1'b0, 2'd0};
        tc[10] = '{4'd2,  64'h4000, 64'h4, 64'h0, 64'h8765_4321_0000_0000, 64'h4000, 8'hF0, 64'h0, 64'hFFFF_FFFF_8765_4321, 1'b0, 2'd0};
        for (int i = 0; i < 11; i++) begin
            do_op(tc[i].op, tc[i].base, tc[i].off, tc[i].sd, tc[i].rdata, 3'(i), 0, 0, 0, 1'b0);
            exp_lat = EXTRA + (tc[i].ex ? 1 : (tc[i].op[3] ? 2 : 3));
            checks++;
            if (o_timeout) begin errors++; $display("FAIL dir_timeout[%0d]: operation did not complete", i); end
            checks++;
            if (o_nreq !== (tc[i].ex ? 0 : 1)) begin
                errors++; $display("FAIL dir_nreq[%0d]: got %0d expected %0d", i, o_nreq, tc[i].ex ? 0 : 1);
            end
            if (!tc[i].ex && o_nreq > 0) begin
                checks++;
                if (o_addr !== tc[i].addr || o_be !== tc[i].be || o_we !== tc[i].op[3]) begin
                    errors++;
                    $display("FAIL dir_mem[%0d]: addr %h be %h we %b expected %h %h %b", i, o_addr, o_be, o_we, tc[i].addr, tc[i].be, tc[i].op[3]);
                end
                if (tc[i].op[3]) begin
                    checks++;
                    if (o_wdata !== tc[i].wdata) begin
                        errors++; $display("FAIL dir_wdata[%0d]: got %h expected %h", i, o_wdata, tc[i].wdata);
                    end
                end
            end
            checks++;
            if (o_data !== tc[i].data || o_ex !== tc[i].ex || o_cause !== tc[i].cause || o_tid !== 3'(i)) begin
                errors++;
                $display("FAIL dir_res[%0d]: data %h ex %b cause %0d id %0d expected %h %b %0d %0d", i, o_data, o_ex, o_cause, o_tid, tc[i].data, tc[i].ex, tc[i].cause, i);
            end
            checks++;
            if (o_lat !== exp_lat) begin
                errors++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, o_lat, exp_lat);
            end
            checks++;
            if (!o_ready_back || !o_hold_ok) begin
                errors++; $display("FAIL dir_handshake[%0d]: ready_back %b hold_ok %b expected 1 1", i, o_ready_back, o_hold_ok);
            end
        end
    endtask

    task automatic test_ld_stall;
        logic [63:0] rdata;
        rdata = {$urandom, $urandom};
        do_op(4'd3, 64'h5000, 64'h18, 64'h0, rdata, 3'd5, 4, 2, 2, 1'b0);
        checks++;
        if (o_timeout || o_nreq !== 5) begin
            errors++; $display("FAIL stall_req: timeout %b req cycles %0d expected 0 5", o_timeout, o_nreq);
        end
        checks++;
        if (!o_stable || o_addr !== 64'h5018 || o_be !== 8'hFF || o_we !== 1'b0) begin
            errors++; $display("FAIL stall_mem: stable %b addr %h be %h we %b expected 1 5018 ff 0", o_stable, o_addr, o_be, o_we);
        end
        checks++;
        if (o_data !== rdata || o_ex !== 1'b0 || o_tid !== 3'd5) begin
            errors++; $display("FAIL stall_res: data %h ex %b id %0d expected %h 0 5", o_data, o_ex, o_tid, rdata);
        end
        checks++;
        if (o_lat !== EXTRA + 9 || !o_hold_ok || !o_ready_back) begin
            errors++; $display("FAIL stall_hold: lat %0d hold %b back %b expected %0d 1 1", o_lat, o_hold_ok, o_ready_back, EXTRA + 9);
        end
    endtask

    task automatic test_random;
        logic [3:0]  rop;
        logic [63:0] rbase, roff, rsd, rrd, e_addr, e_wdata, e_data;
        logic [7:0]  e_be;
        logic        e_ex;
        logic [1:0]  e_cause;
        logic [2:0]  rtid;
        bit          e_st;
        int          gd, rd, rr, s, exp_lat;
        for (int i = 0; i < 150; i++) begin
            rop = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 11));
            if (rop == 4'd7 && $urandom_range(0, 1) == 1) rop = 4'd3;
            rbase = {$urandom, $urandom};
            if ($urandom_range(0, 2) != 0) rbase[2:0] = 3'd0;
            s = int'($urandom_range(0, 63)) - 32;
            roff = 64'(longint'(s));
            rsd = {$urandom, $urandom};
            rrd = {$urandom, $urandom};
            rtid = 3'($urandom);
            gd = $urandom_range(0, 3); rd = $urandom_range(0, 3); rr = $urandom_range(0, 2);
            model(rop, rbase, roff, rsd, rrd, e_addr, e_be, e_wdata, e_data, e_ex, e_cause, e_st);
            exp_lat = EXTRA + (e_ex ? 1 : (e_st ? gd + 2 : gd + rd + 3));
            do_op(rop, rbase, roff, rsd, rrd, rtid, gd, rd, rr, 1'b1);
            checks++;
            if (o_timeout || o_nreq !== (e_ex ? 0 : gd + 1) || (!e_ex && !o_stable)) begin
                errors++;
                $display("FAIL rnd_req[%0d]: op %0d timeout %b req %0d stable %b expected req %0d", i, rop, o_timeout, o_nreq, o_stable, e_ex ? 0 : gd + 1);
            end
            if (!e_ex) begin
                checks++;
                if (o_addr !== e_addr || o_be !== e_be || o_we !== e_st || (e_st && o_wdata !== e_wdata)) begin
                    errors++;
                    $display("FAIL rnd_mem[%0d]: op %0d addr %h be %h we %b wdata %h expected %h %h %b %h", i, rop, o_addr, o_be, o_we, o_wdata, e_addr, e_be, e_st, e_wdata);
                end
            end
            checks++;
            if (o_data !== e_data || o_ex !== e_ex || o_cause !== e_cause || o_tid !== rtid) begin
                errors++;
                $display("FAIL rnd_res[%0d]: op %0d data %h ex %b cause %0d id %0d expected %h %b %0d %0d", i, rop, o_data, o_ex, o_cause, o_tid, e_data, e_ex, e_cause, rtid);
            end
            checks++;
            if (o_lat !== exp_lat || !o_hold_ok || !o_ready_back) begin
                errors++;
                $display("FAIL rnd_timing[%0d]: lat %0d hold %b back %b expected %0d 1 1", i, o_lat, o_hold_ok, o_ready_back, exp_lat);
            end
        end
    endtask

    task automatic test_reset_midop;
        int  cyc;
        bit  bad_valid;
        @(negedge clk);
        op_valid = 1'b1; op = 4'd3; base = 64'h6000; offset = 64'h8; trans_id = 3'd2;
        @(posedge clk);
        #1 op_valid = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!mem_req && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!mem_req) begin
            errors++; $display("FAIL midop_req: got mem_req 0 expected 1");
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bad_valid = 0;
        for (int k = 0; k < 3; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata = {$urandom, $urandom};
            @(negedge clk);
            if (res_valid || !op_ready) bad_valid = 1;
        end
        mem_rvalid = 1'b0;
        checks++;
        if (bad_valid) begin
            errors++; $display("FAIL midop_stray: res_valid/op_ready changed after reset, expected 0/1");
        end
        checks++;
        if ({op_ready, mem_req, mem_we, res_valid, res_ex} !== 5'b10000 || mem_be !== 8'h00 ||
            mem_addr !== 64'd0 || res_data !== 64'd0 || res_trans_id !== 3'd0) begin
            errors++;
            $display("FAIL midop_outputs: ctrl %b be %h addr %h data %h id %0d expected 10000 and zeros",
                     {op_ready, mem_req, mem_we, res_valid, res_ex}, mem_be, mem_addr, res_data, res_trans_id);
        end
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op = '0; base = '0; offset = '0; sdata = '0; trans_id = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; res_ready = 1'b0;
        test_reset;
        test_directed;
        test_ld_stall;
        test_random;
        test_reset_midop;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
